// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared widths, default frame size and sequencer states
package fb_pkg;
   localparam int FB_ADDR_W = 19;
   localparam int X_W       = 10;
   localparam int Y_W       = 9;
   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fb_state_t;
endpackage

// File: rtl/fb_pixel_writer_if.sv
// rtl/fb_pixel_writer_if.sv - coordinate, pixel-result and frame-buffer write signals
interface fb_pixel_writer_if #(parameter int PIX_W = 8);
   import fb_pkg::*;

   logic [X_W-1:0]       coord_x;
   logic [Y_W-1:0]       coord_y;
   logic                 coord_valid;
   logic                 coord_ready;
   logic [PIX_W-1:0]     pix_data;
   logic                 pix_valid;
   logic                 pix_ready;
   logic                 fb_we;
   logic [FB_ADDR_W-1:0] fb_addr;
   logic [PIX_W-1:0]     fb_data;

   modport master (
      output coord_x, coord_y, coord_valid,
      input  coord_ready,
      input  pix_data, pix_valid,
      output pix_ready,
      output fb_we, fb_addr, fb_data
   );

   modport slave (
      input  coord_x, coord_y, coord_valid,
      output coord_ready,
      output pix_data, pix_valid,
      input  pix_ready,
      input  fb_we, fb_addr, fb_data
   );
endinterface

// File: rtl/raster_coord_counter.sv
// rtl/raster_coord_counter.sv - raster-order x/y counter with wrap and last-pixel flag
module raster_coord_counter
   import fb_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clear,
   input  logic           en,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);
   logic x_end;
   logic y_end;

   assign x_end = (x == X_W'(H_RES - 1));
   assign y_end = (y == Y_W'(V_RES - 1));
   assign last  = x_end && y_end;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (x_end) begin
            x <= '0;
            y <= y_end ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end
endmodule

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - raster sweep issuer and in-order frame-buffer writer
module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int H_RES   = H_RES_DEF,
   parameter int V_RES   = V_RES_DEF,
   parameter int PIX_W   = 8,
   parameter int MAX_OUT = 16
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               start,
   fb_pixel_writer_if.master  bus,
   output logic               busy,
   output logic               done
);
   localparam int OUT_W = $clog2(MAX_OUT) + 1;
   localparam logic [FB_ADDR_W-1:0] PIX_TOTAL = FB_ADDR_W'(H_RES * V_RES);

   fb_state_t            state, state_nxt;
   logic [OUT_W-1:0]     outstanding;
   logic [FB_ADDR_W-1:0] wr_cnt;
   logic                 coord_valid, pix_ready, coord_hs, pix_hs, coord_last, clear;
   logic                 fb_we_q;
   logic [FB_ADDR_W-1:0] fb_addr_q;
   logic [PIX_W-1:0]     fb_data_q;
   logic [X_W-1:0]       cx;
   logic [Y_W-1:0]       cy;

   raster_coord_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_coord (
      .clk   (Clk),
      .reset (Reset),
      .clear (clear),
      .en    (coord_hs),
      .x     (cx),
      .y     (cy),
      .last  (coord_last)
   );

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      coord_valid = 1'b0;
      pix_ready   = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      clear       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               clear     = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            coord_valid = (outstanding < OUT_W'(MAX_OUT));
            pix_ready   = (outstanding != '0);
            if (coord_valid && bus.coord_ready && coord_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            pix_ready = (outstanding != '0);
            // wr_cnt reaches the total the cycle the final write is on the bus
            if (wr_cnt == PIX_TOTAL) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign coord_hs = coord_valid && bus.coord_ready;
   assign pix_hs   = pix_ready && bus.pix_valid;

   always_ff @(posedge Clk) begin
      if (Reset || clear) begin
         outstanding <= '0;
      end else begin
         case ({coord_hs, pix_hs})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         fb_we_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
         wr_cnt    <= '0;
      end else begin
         fb_we_q <= pix_hs;
         if (pix_hs) begin
            fb_addr_q <= wr_cnt;
            fb_data_q <= bus.pix_data;
         end
         if (clear)       wr_cnt <= '0;
         else if (pix_hs) wr_cnt <= wr_cnt + 1'b1;
      end
   end

   assign bus.coord_x     = cx;
   assign bus.coord_y     = cy;
   assign bus.coord_valid = coord_valid;
   assign bus.pix_ready   = pix_ready;
   assign bus.fb_we       = fb_we_q;
   assign bus.fb_addr     = fb_addr_q;
   assign bus.fb_data     = fb_data_q;
endmodule
